// File: rtl/cv_checkers_monitor.sv
// Self-check receiver for the composite-video checkers pattern: recomputes the expected
// luminance from the shared pixel timing and counts mismatches over N_FRAMES whole frames.
module cv_checkers_monitor #(
    parameter int unsigned MAX_PIXEL_H   = 1280,
    parameter int unsigned MAX_SCANLINES = 625,
    parameter int unsigned CHECKERS_SIZE = 8,
    parameter int unsigned N_FRAMES      = 2,
    parameter int unsigned ERR_W         = 16,
    localparam int unsigned XW = $clog2(MAX_PIXEL_H),
    localparam int unsigned YW = $clog2(MAX_SCANLINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             clk_en_pixel,
    input  logic             x_vis,
    input  logic [XW-1:0]    x_pos,
    input  logic [YW-1:0]    y_pos,
    input  logic [1:0]       lum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [ERR_W-1:0] err_count,
    output logic [XW-1:0]    first_err_x,
    output logic [YW-1:0]    first_err_y
);
    localparam int unsigned S  = $clog2(CHECKERS_SIZE);
    localparam int unsigned FW = $clog2(N_FRAMES + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, CHECK} state_t;

    state_t            state, state_d;
    logic [1:0]        exp_q, exp_d;
    logic              exp_valid, exp_valid_d;
    logic [XW-1:0]     pos_x_q, pos_x_d;
    logic [YW-1:0]     pos_y_q, pos_y_d;
    logic [FW-1:0]     frame_cnt, frame_d;
    logic [ERR_W-1:0]  err_d;
    logic [XW-1:0]     first_x_d;
    logic [YW-1:0]     first_y_d;
    logic              pass_d, aborted_d, done_d;
    logic              fs_c;
    logic [1:0]        exp_c;

    // Checker colour: horizontal square index bits folded with the vertical square parity.
    assign exp_c = x_vis ? (2'(x_pos >> S) ^ {2{y_pos[S]}}) : 2'b00;
    assign fs_c  = clk_en_pixel && (x_pos == '0) && (y_pos == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            exp_q       <= '0;
            exp_valid   <= 1'b0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            frame_cnt   <= '0;
            err_count   <= '0;
            first_err_x <= '0;
            first_err_y <= '0;
            pass        <= 1'b0;
            aborted     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            exp_q       <= exp_d;
            exp_valid   <= exp_valid_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            frame_cnt   <= frame_d;
            err_count   <= err_d;
            first_err_x <= first_x_d;
            first_err_y <= first_y_d;
            pass        <= pass_d;
            aborted     <= aborted_d;
            done        <= done_d;
            busy        <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d     = state;
        exp_d       = exp_q;
        exp_valid_d = exp_valid;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        frame_d     = frame_cnt;
        err_d       = err_count;
        first_x_d   = first_err_x;
        first_y_d   = first_err_y;
        pass_d      = pass;
        aborted_d   = aborted;
        done_d      = 1'b0;

        case (state)
            IDLE: begin
                if (start && en) begin
                    state_d     = ARM;
                    err_d       = '0;
                    first_x_d   = '0;
                    first_y_d   = '0;
                    pass_d      = 1'b0;
                    aborted_d   = 1'b0;
                    frame_d     = '0;
                    exp_valid_d = 1'b0;
                end
            end
            ARM: begin
                if (!en) begin
                    state_d     = IDLE;
                    aborted_d   = 1'b1;
                    exp_valid_d = 1'b0;
                end else if (fs_c) begin
                    state_d     = CHECK;
                    exp_d       = exp_c;
                    pos_x_d     = x_pos;
                    pos_y_d     = y_pos;
                    exp_valid_d = 1'b1;
                end
            end
            CHECK: begin
                if (!en) begin
                    state_d     = IDLE;
                    aborted_d   = 1'b1;
                    exp_valid_d = 1'b0;
                end else if (clk_en_pixel) begin
                    // lum now carries the pixel whose expectation was registered last strobe
                    if (exp_valid && (lum != exp_q)) begin
                        if (err_count != ERR_MAX) begin
                            err_d = err_count + 1'b1;
                        end
                        if (err_count == '0) begin
                            first_x_d = pos_x_q;
                            first_y_d = pos_y_q;
                        end
                    end
                    exp_d       = exp_c;
                    pos_x_d     = x_pos;
                    pos_y_d     = y_pos;
                    exp_valid_d = 1'b1;
                    if (fs_c) begin
                        frame_d = frame_cnt + 1'b1;
                        if (frame_d == FW'(N_FRAMES)) begin
                            state_d     = IDLE;
                            done_d      = 1'b1;
                            pass_d      = (err_d == '0);
                            exp_valid_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cv_checkers_monitor.sv
// Bench for cv_checkers_monitor: a checkers generator model with error injection drives two
// monitors (16-bit and 4-bit error counters); run results are checked through a scoreboard.
module tb_cv_checkers_monitor;
    localparam int H_TOT = 104;
    localparam int V_TOT = 51;
    localparam int H_VIS = 102;
    localparam int RUN_BUDGET = 25000;

    typedef struct packed {
        logic        p;
        logic [15:0] err;
        logic [10:0] fx;
        logic [9:0]  fy;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        clk_en_pixel = 1'b0;
    logic        x_vis = 1'b1;
    logic [10:0] xpos = '0;
    logic [9:0]  ypos = '0;
    logic [1:0]  lum = '0;
    logic [1:0]  lum_b = '0;

    logic        busy, done, pass, aborted;
    logic [15:0] err_count;
    logic [10:0] first_err_x;
    logic [9:0]  first_err_y;
    logic        busy2, done2, pass2, aborted2;
    logic [3:0]  err_count2;
    logic [10:0] first_err_x2;
    logic [9:0]  first_err_y2;

    int   checks = 0;
    int   failures = 0;
    int   gen_frame = 0;
    int   f0 = -1;
    int   mode_a = 0;
    int   mode_b = 0;
    int   div = 0;
    int   done_cnt = 0;
    res_t exp_q_a[$];
    res_t exp_q_b[$];

    cv_checkers_monitor dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .clk_en_pixel(clk_en_pixel),
        .x_vis(x_vis), .x_pos(xpos), .y_pos(ypos), .lum(lum),
        .busy(busy), .done(done), .pass(pass), .aborted(aborted), .err_count(err_count),
        .first_err_x(first_err_x), .first_err_y(first_err_y)
    );

    cv_checkers_monitor #(.ERR_W(4)) dut2 (
        .clk(clk), .reset(reset), .en(en), .start(start), .clk_en_pixel(clk_en_pixel),
        .x_vis(x_vis), .x_pos(xpos), .y_pos(ypos), .lum(lum_b),
        .busy(busy2), .done(done2), .pass(pass2), .aborted(aborted2), .err_count(err_count2),
        .first_err_x(first_err_x2), .first_err_y(first_err_y2)
    );

    always #5 clk = ~clk;

    // Generator model: registered lum for the pixel just strobed, then advance the raster.
    always @(negedge clk) begin
        logic [1:0] g;
        if (clk_en_pixel) begin
            g = (xpos < 11'(H_VIS)) ? ({xpos[4], xpos[3]} ^ {2{ypos[3]}}) : 2'b00;
            lum = g;
            lum_b = g;
            if (gen_frame == f0) begin
                if (mode_a == 2 && xpos == 11'd100 && ypos == 10'd50) lum = g ^ 2'b01;
                if (mode_b == 4 && ypos == 10'd10 && xpos < 11'd40) lum_b = ~g;
                if (mode_b == 3 && xpos == 11'd103 && ypos >= 10'd5 && ypos <= 10'd7) lum_b = 2'b11;
            end
            if (xpos == 11'(H_TOT - 1)) begin
                xpos = '0;
                if (ypos == 10'(V_TOT - 1)) begin
                    ypos = '0;
                    gen_frame++;
                end else begin
                    ypos = ypos + 10'd1;
                end
            end else begin
                xpos = xpos + 11'd1;
            end
            x_vis = (xpos < 11'(H_VIS));
        end
        div = (div + 1) % 8;
        clk_en_pixel = (div != 7);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_aborted"}, 32'(aborted), 0);
        check({tag, "_err"}, 32'(err_count), 0);
        check({tag, "_fx"}, 32'(first_err_x), 0);
        check({tag, "_fy"}, 32'(first_err_y), 0);
        check({tag, "_err2"}, 32'(err_count2), 0);
    endtask

    task automatic wait_line(input int f, input int yy);
        int n = 0;
        while (!(gen_frame == f && ypos == 10'(yy)) && n < RUN_BUDGET) begin
            tick();
            n++;
        end
        if (n >= RUN_BUDGET) check("wait_line_timeout", 32'(n), 0);
    endtask

    // Arm a run a few pixels before a frame boundary so frame f0 is the first checked frame.
    task automatic start_run(input int ma, input int mb, input res_t ea, input res_t eb);
        int n = 0;
        while (!(ypos == 10'(V_TOT - 1) && xpos == 11'(H_TOT - 20)) && n < RUN_BUDGET) begin
            tick();
            n++;
        end
        if (n >= RUN_BUDGET) check("wait_frame_end_timeout", 32'(n), 0);
        mode_a = ma;
        mode_b = mb;
        f0 = gen_frame + 1;
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic collect(input string tag);
        int   n = 0;
        res_t ea, eb;
        while (!done && n < RUN_BUDGET) begin
            tick();
            n++;
        end
        if (n >= RUN_BUDGET) begin
            check({tag, "_done_timeout"}, 32'(n), 0);
            exp_q_a.delete();
            exp_q_b.delete();
        end else begin
            ea = exp_q_a.pop_front();
            eb = exp_q_b.pop_front();
            check({tag, "_done_frame"}, 32'(gen_frame), 32'(f0 + 2));
            check({tag, "_done2"}, 32'(done2), 1);
            check({tag, "_pass"}, 32'(pass), 32'(ea.p));
            check({tag, "_err"}, 32'(err_count), 32'(ea.err));
            check({tag, "_fx"}, 32'(first_err_x), 32'(ea.fx));
            check({tag, "_fy"}, 32'(first_err_y), 32'(ea.fy));
            check({tag, "_pass2"}, 32'(pass2), 32'(eb.p));
            check({tag, "_err2"}, 32'(err_count2), 32'(eb.err));
            check({tag, "_fx2"}, 32'(first_err_x2), 32'(eb.fx));
            check({tag, "_fy2"}, 32'(first_err_y2), 32'(eb.fy));
            tick();
            check({tag, "_done_pulse"}, 32'(done), 0);
            check({tag, "_busy_after"}, 32'(busy), 0);
            check({tag, "_pass_held"}, 32'(pass), 32'(ea.p));
        end
        mode_a = 0;
        mode_b = 0;
    endtask

    initial begin
        int dc;
        #2;
        check_all_zero("reset_init");
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Run A: clean on the wide monitor; 40 inverted pixels saturate the 4-bit counter.
        start_run(0, 4, '{p: 1'b1, err: 16'd0, fx: 11'd0, fy: 10'd0},
                        '{p: 1'b0, err: 16'd15, fx: 11'd0, fy: 10'd10});
        wait_line(f0, 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        collect("runA");

        // Run B: one visible flip on the wide monitor; three forced blanking pixels on the narrow.
        start_run(2, 3, '{p: 1'b0, err: 16'd1, fx: 11'd100, fy: 10'd50},
                        '{p: 1'b0, err: 16'd3, fx: 11'd103, fy: 10'd5});
        collect("runB");

        // Abort by dropping en in the middle of the first checked frame.
        start_run(0, 0, '0, '0);
        wait_line(f0, 20);
        dc = done_cnt;
        en = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_aborted", 32'(aborted), 1);
        check("abort_err_kept", 32'(err_count), 0);
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_sticky", 32'(aborted), 1);
        exp_q_a.delete();
        exp_q_b.delete();
        en = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_clears_aborted", 32'(aborted), 0);
        check("restart_busy", 32'(busy), 1);

        // Reset while checking, then reset during a pixel strobe.
        wait_line(gen_frame + 1, 3);
        check("pre_reset_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("reset_mid_check");
        tick();
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_line(gen_frame + 1, 2);
        while (!clk_en_pixel) tick();
        check("pre_reset2_busy", 32'(busy), 1);
        #1 reset = 1'b0;
        #1 check_all_zero("reset_mid_strobe");
        tick();
        reset = 1'b1;
        tick();

        // Run C: a fresh run after reset passes on both monitors.
        start_run(0, 0, '{p: 1'b1, err: 16'd0, fx: 11'd0, fy: 10'd0},
                        '{p: 1'b1, err: 16'd0, fx: 11'd0, fy: 10'd0});
        collect("runC");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
